// File: rtl/jtframe_sdram_resp.sv
// Two-slot SDRAM request arbiter/sequencer: grants one requester, issues a command and
// collects a two-beat read or a write ack. `JTFRAME_SDRAM_RESP_FIXPRIO_EN selects fixed priority.
module jtframe_sdram_resp #(
  parameter int unsigned TOUT = 1023
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        slot0_req_i,
  input  logic        slot0_rnw_i,
  input  logic [21:0] slot0_addr_i,
  input  logic [15:0] slot0_wrdata_i,
  output logic        slot0_we_o,
  output logic [31:0] slot0_din_o,
  output logic        slot0_din_ok_o,
  input  logic        slot1_req_i,
  input  logic        slot1_rnw_i,
  input  logic [21:0] slot1_addr_i,
  input  logic [15:0] slot1_wrdata_i,
  output logic        slot1_we_o,
  output logic [31:0] slot1_din_o,
  output logic        slot1_din_ok_o,
  output logic        mem_req_o,
  output logic        mem_rnw_o,
  output logic [21:0] mem_addr_o,
  output logic [15:0] mem_wdata_o,
  input  logic        mem_ack_i,
  input  logic        mem_rdy_i,
  input  logic [15:0] mem_rdata_i
);

  localparam int unsigned WdW = $clog2(TOUT + 1);

  typedef enum logic [2:0] {StIdle, StCmd, StBeat0, StBeat1, StDone} state_e;

  state_e        state_q, state_d;
  logic          slot_q, slot_d;
  logic          rnw_q, rnw_d;
  logic [21:0]   addr_q, addr_d;
  logic [15:0]   wdata_q, wdata_d;
  logic [15:0]   lo_q, lo_d;
  logic [31:0]   din0_q, din0_d, din1_q, din1_d;
  logic [WdW-1:0] wd_q, wd_d;
  logic          post_done_q;
  logic          elig0, elig1, gnt;
  logic          timeout;
  logic          rd_done;
  logic [31:0]   rd_data;

  // wd_q counts completed active cycles, so the forced DONE lands TOUT cycles after grant
  assign timeout = (wd_q == WdW'(TOUT - 2));

  always_comb begin
`ifdef JTFRAME_SDRAM_RESP_FIXPRIO_EN
    // First IDLE cycle after DONE grants nobody, so slot0 keeps winning while it requests
    elig0 = slot0_req_i & ~post_done_q;
    elig1 = slot1_req_i & ~post_done_q;
    gnt   = ~elig0;
`else
    elig0 = slot0_req_i & ~(post_done_q & ~slot_q);
    elig1 = slot1_req_i & ~(post_done_q & slot_q);
    gnt   = (elig0 & elig1) ? ~slot_q : elig1;
`endif
  end

  always_comb begin
    state_d = state_q;
    slot_d  = slot_q;
    rnw_d   = rnw_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    lo_d    = lo_q;
    din0_d  = din0_q;
    din1_d  = din1_q;
    wd_d    = wd_q;
    rd_done = 1'b0;
    rd_data = 32'h0;
    unique case (state_q)
      StIdle: begin
        if (elig0 | elig1) begin
          slot_d  = gnt;
          rnw_d   = gnt ? slot1_rnw_i : slot0_rnw_i;
          addr_d  = gnt ? slot1_addr_i : slot0_addr_i;
          wdata_d = gnt ? slot1_wrdata_i : slot0_wrdata_i;
          wd_d    = '0;
          state_d = StCmd;
        end
      end
      StCmd: begin
        wd_d = wd_q + WdW'(1);
        if (timeout) begin
          rd_done = rnw_q;
          rd_data = 32'hFFFF_FFFF;
          state_d = StDone;
        end else if (mem_ack_i) begin
          state_d = rnw_q ? StBeat0 : StDone;
        end
      end
      StBeat0: begin
        wd_d = wd_q + WdW'(1);
        if (timeout) begin
          rd_done = 1'b1;
          rd_data = 32'hFFFF_FFFF;
          state_d = StDone;
        end else if (mem_rdy_i) begin
          lo_d    = mem_rdata_i;
          state_d = StBeat1;
        end
      end
      StBeat1: begin
        wd_d = wd_q + WdW'(1);
        if (timeout) begin
          rd_done = 1'b1;
          rd_data = 32'hFFFF_FFFF;
          state_d = StDone;
        end else if (mem_rdy_i) begin
          rd_done = 1'b1;
          rd_data = {mem_rdata_i, lo_q};
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
    // din only changes on entry to DONE so it stays stable until the next read completes
    if (rd_done) begin
      if (slot_q) din1_d = rd_data;
      else        din0_d = rd_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      slot_q      <= 1'b1;
      rnw_q       <= 1'b1;
      addr_q      <= 22'h0;
      wdata_q     <= 16'h0;
      lo_q        <= 16'h0;
      din0_q      <= 32'h0;
      din1_q      <= 32'h0;
      wd_q        <= '0;
      post_done_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      rnw_q       <= rnw_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      lo_q        <= lo_d;
      din0_q      <= din0_d;
      din1_q      <= din1_d;
      wd_q        <= wd_d;
      post_done_q <= (state_q == StDone);
    end
  end

  assign slot0_we_o     = (state_q != StIdle) & ~slot_q;
  assign slot1_we_o     = (state_q != StIdle) & slot_q;
  assign slot0_din_ok_o = (state_q == StDone) & ~slot_q;
  assign slot1_din_ok_o = (state_q == StDone) & slot_q;
  assign slot0_din_o    = din0_q;
  assign slot1_din_o    = din1_q;
  assign mem_req_o      = (state_q == StCmd);
  assign mem_rnw_o      = rnw_q;
  assign mem_addr_o     = addr_q;
  assign mem_wdata_o    = wdata_q;

endmodule

// File: tb/tb_jtframe_sdram_resp.sv
// Scoreboard bench for jtframe_sdram_resp: a behavioural memory back end checks commands,
// a monitor checks every completion strobe against queued expectations.
module tb_jtframe_sdram_resp;

  logic        clk = 1'b0;
  logic        rst;
  logic        slot0_req_i, slot0_rnw_i, slot1_req_i, slot1_rnw_i;
  logic [21:0] slot0_addr_i, slot1_addr_i;
  logic [15:0] slot0_wrdata_i, slot1_wrdata_i;
  logic        slot0_we_o, slot1_we_o, slot0_din_ok_o, slot1_din_ok_o;
  logic [31:0] slot0_din_o, slot1_din_o;
  logic        mem_req_o, mem_rnw_o, mem_ack_i, mem_rdy_i;
  logic [21:0] mem_addr_o;
  logic [15:0] mem_wdata_o, mem_rdata_i;

  jtframe_sdram_resp #(.TOUT(15)) dut (
    .clk(clk), .rst(rst),
    .slot0_req_i(slot0_req_i), .slot0_rnw_i(slot0_rnw_i), .slot0_addr_i(slot0_addr_i),
    .slot0_wrdata_i(slot0_wrdata_i), .slot0_we_o(slot0_we_o), .slot0_din_o(slot0_din_o),
    .slot0_din_ok_o(slot0_din_ok_o),
    .slot1_req_i(slot1_req_i), .slot1_rnw_i(slot1_rnw_i), .slot1_addr_i(slot1_addr_i),
    .slot1_wrdata_i(slot1_wrdata_i), .slot1_we_o(slot1_we_o), .slot1_din_o(slot1_din_o),
    .slot1_din_ok_o(slot1_din_ok_o),
    .mem_req_o(mem_req_o), .mem_rnw_o(mem_rnw_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_ack_i(mem_ack_i), .mem_rdy_i(mem_rdy_i),
    .mem_rdata_i(mem_rdata_i)
  );

  always #5 clk = ~clk;

  typedef struct {logic rnw; logic [21:0] addr; logic [15:0] wd;} cmd_t;
  typedef struct {logic slot; logic [31:0] d0; logic [31:0] d1; int lat;} res_t;

  cmd_t        cmd_q[$];
  res_t        sb_q[$];
  logic [31:0] exp_din [2];
  int          n_vec = 0, n_err = 0;

  int          ack_delay = 0;
  bit          rdy_on = 1'b1, stall_hi = 1'b0, noise = 1'b0, fix_beats = 1'b0;
  logic [15:0] fix_lo = 16'h0, fix_hi = 16'h0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] model_din(input logic [21:0] a);
    return {{10'h0, a[21:16]} ^ 16'hC3C3, a[15:0]};
  endfunction

  // Memory back end
  initial begin
    int          req_cnt = 0;
    int          pend = 0;
    logic [21:0] a_lat = 22'h0;
    cmd_t        c;
    logic [31:0] beats;
    mem_ack_i = 1'b0; mem_rdy_i = 1'b0; mem_rdata_i = 16'h0;
    forever begin
      @(negedge clk);
      mem_ack_i   = 1'b0;
      mem_rdy_i   = noise;
      mem_rdata_i = 16'h1234;
      beats = fix_beats ? {fix_hi, fix_lo} : model_din(a_lat);
      if (mem_req_o) begin
        if (req_cnt >= ack_delay) begin
          mem_ack_i = 1'b1;
          req_cnt   = 0;
          pend      = mem_rnw_o ? 2 : 0;
          a_lat     = mem_addr_o;
          if (cmd_q.size() == 0) check("cmd_unexpected", 1, 0);
          else begin
            c = cmd_q.pop_front();
            check("cmd_rnw", mem_rnw_o, c.rnw);
            check("cmd_addr", mem_addr_o, c.addr);
            if (!c.rnw) check("cmd_wdata", mem_wdata_o, c.wd);
          end
        end else req_cnt++;
      end else begin
        req_cnt = 0;
        if (!rdy_on) pend = 0;
        if (pend == 2) begin
          mem_rdy_i = 1'b1; mem_rdata_i = beats[15:0]; pend = 1;
        end else if (pend == 1 && !stall_hi) begin
          mem_rdy_i = 1'b1; mem_rdata_i = beats[31:16]; pend = 0;
        end
      end
    end
  end

  // Completion monitor
  initial begin
    int   cyc = 0;
    int   g_cyc [2];
    logic we0_p = 1'b0, we1_p = 1'b0;
    res_t e;
    g_cyc[0] = 0; g_cyc[1] = 0;
    forever begin
      @(negedge clk);
      cyc++;
      if (slot0_we_o && !we0_p) g_cyc[0] = cyc;
      if (slot1_we_o && !we1_p) g_cyc[1] = cyc;
      we0_p = slot0_we_o; we1_p = slot1_we_o;
      if (slot0_din_ok_o || slot1_din_ok_o) begin
        if (sb_q.size() == 0) check("ok_unexpected", {slot1_din_ok_o, slot0_din_ok_o}, 0);
        else begin
          e = sb_q.pop_front();
          check("ok_slot", {slot1_din_ok_o, slot0_din_ok_o}, e.slot ? 2'b10 : 2'b01);
          check("ok_we", {slot1_we_o, slot0_we_o}, e.slot ? 2'b10 : 2'b01);
          check("din0", slot0_din_o, e.d0);
          check("din1", slot1_din_o, e.d1);
          if (e.lat > 0) check("latency", cyc - g_cyc[e.slot] + 1, e.lat);
        end
      end
    end
  end

  task automatic check_reset(input string tag);
    check({tag, "_we"}, {slot1_we_o, slot0_we_o}, 0);
    check({tag, "_ok"}, {slot1_din_ok_o, slot0_din_ok_o}, 0);
    check({tag, "_din0"}, slot0_din_o, 0);
    check({tag, "_din1"}, slot1_din_o, 0);
    check({tag, "_mreq"}, mem_req_o, 0);
    check({tag, "_mrnw"}, mem_rnw_o, 1);
    check({tag, "_maddr"}, mem_addr_o, 0);
    check({tag, "_mwd"}, mem_wdata_o, 0);
  endtask

  task automatic wait_ok(input logic s);
    bit seen = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (s ? slot1_din_ok_o : slot0_din_ok_o) begin seen = 1'b1; break; end
    end
    if (!seen) check("wait_ok", 0, 1);
  endtask

  task automatic drive(input logic s, input logic req, input logic rnw, input logic [21:0] a,
                       input logic [15:0] wd);
    if (!s) begin
      slot0_req_i = req; slot0_rnw_i = rnw; slot0_addr_i = a; slot0_wrdata_i = wd;
    end else begin
      slot1_req_i = req; slot1_rnw_i = rnw; slot1_addr_i = a; slot1_wrdata_i = wd;
    end
  endtask

  task automatic expect_res(input logic s, input logic rnw, input logic [31:0] rd,
                            input int lat);
    res_t e;
    if (rnw) exp_din[s] = rd;
    e.slot = s; e.d0 = exp_din[0]; e.d1 = exp_din[1]; e.lat = lat;
    sb_q.push_back(e);
  endtask

  task automatic expect_cmd(input logic rnw, input logic [21:0] a, input logic [15:0] wd);
    cmd_t c;
    c.rnw = rnw; c.addr = a; c.wd = wd;
    cmd_q.push_back(c);
  endtask

  // Requester holds req through the first IDLE cycle after din_ok, then drops it
  task automatic issue(input logic s, input logic rnw, input logic [21:0] a,
                       input logic [15:0] wd, input int lat, input logic acked,
                       input logic [31:0] rd);
    if (acked) expect_cmd(rnw, a, wd);
    expect_res(s, rnw, rd, lat);
    drive(s, 1'b1, rnw, a, wd);
    wait_ok(s);
    @(negedge clk);
    drive(s, 1'b0, rnw, a, wd);
  endtask

  initial begin
    #500000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1);
  end

  initial begin
    int  n;
    bit  seen;
    exp_din[0] = 32'h0; exp_din[1] = 32'h0;
    rst = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 22'h0, 16'h0);
    drive(1'b1, 1'b0, 1'b0, 22'h0, 16'h0);
    repeat (3) @(negedge clk);
    check_reset("rst_hold");
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst_rel");

    fix_beats = 1'b1; fix_lo = 16'hBEEF; fix_hi = 16'hDEAD;
    issue(1'b0, 1'b1, 22'h0123, 16'h0, 4, 1'b1, 32'hDEAD_BEEF);
    fix_beats = 1'b0;

    ack_delay = 3;
    issue(1'b1, 1'b0, 22'h3FFFFF, 16'h5A5A, 5, 1'b1, 32'h0);
    ack_delay = 0;
    issue(1'b0, 1'b0, 22'h00ABC, 16'h1357, 2, 1'b1, 32'h0);
    noise = 1'b1;
    issue(1'b1, 1'b1, 22'h2A5F1, 16'h0, 4, 1'b1, model_din(22'h2A5F1));
    noise = 1'b0;

    // Both slots request continuously; last served was slot1, so grants go 0,1,0,1
    expect_cmd(1'b1, 22'h10001, 16'h0); expect_res(1'b0, 1'b1, model_din(22'h10001), 4);
    expect_cmd(1'b1, 22'h20001, 16'h0); expect_res(1'b1, 1'b1, model_din(22'h20001), 4);
    expect_cmd(1'b1, 22'h10002, 16'h0); expect_res(1'b0, 1'b1, model_din(22'h10002), 4);
    expect_cmd(1'b1, 22'h20002, 16'h0); expect_res(1'b1, 1'b1, model_din(22'h20002), 4);
    drive(1'b0, 1'b1, 1'b1, 22'h10001, 16'h0);
    drive(1'b1, 1'b1, 1'b1, 22'h20001, 16'h0);
    n = 0;
    for (int i = 0; i < 100 && n < 4; i++) begin
      @(negedge clk);
      if (slot0_din_ok_o) begin slot0_addr_i = 22'h10002; n++; end
      if (slot1_din_ok_o) begin slot1_addr_i = 22'h20002; n++; end
      if (n == 4) begin slot0_req_i = 1'b0; slot1_req_i = 1'b0; end
    end
    check("tie_count", n, 4);
    slot0_req_i = 1'b0; slot1_req_i = 1'b0;

    rdy_on = 1'b0;
    issue(1'b1, 1'b1, 22'h15555, 16'h0, 15, 1'b1, 32'hFFFF_FFFF);
    rdy_on = 1'b1;
    @(negedge clk);
    check("wd_idle_mreq", mem_req_o, 0);
    check("wd_idle_we", {slot1_we_o, slot0_we_o}, 0);

    ack_delay = 100;
    issue(1'b0, 1'b0, 22'h00777, 16'hBBBB, 15, 1'b0, 32'h0);
    ack_delay = 0;

    // Reset while stalled in the second beat
    stall_hi = 1'b1;
    expect_cmd(1'b1, 22'h1F00F, 16'h0);
    drive(1'b0, 1'b1, 1'b1, 22'h1F00F, 16'h0);
    seen = 1'b0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (slot0_we_o) begin seen = 1'b1; break; end
    end
    check("rst_grant", seen, 1);
    repeat (2) @(negedge clk);
    rst = 1'b1;
    slot0_req_i = 1'b0;
    exp_din[0] = 32'h0; exp_din[1] = 32'h0;
    @(negedge clk);
    check_reset("rst_mid");
    rst = 1'b0;
    @(negedge clk);
    stall_hi = 1'b0;
    repeat (3) @(negedge clk);
    check_reset("rst_late");

    issue(1'b0, 1'b1, 22'h0F0F0, 16'h0, 4, 1'b1, model_din(22'h0F0F0));
    repeat (4) @(negedge clk);
    check("sb_drained", sb_q.size(), 0);
    check("cmd_drained", cmd_q.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
